// File: rtl/uart_frame_pkg.sv
// Shared types and constants for the UART receive-side frame controller.
package uart_frame_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RECV   = 2'd1,
        ST_CHECK  = 2'd2,
        ST_TX_REQ = 2'd3
    } frame_state_t;

    localparam logic [7:0] DEFAULT_HEADER   = 8'hAA;
    localparam logic [7:0] DEFAULT_ACK_BYTE = 8'h06;
    localparam logic [7:0] DEFAULT_NAK_BYTE = 8'h15;

    // Five payload bytes followed by one checksum byte; the header is not counted.
    localparam int FRAME_LEN = 6;
    localparam int TIMER_W   = 16;

    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/byte_timeout.sv
// Inter-byte silence timer: counts enabled cycles since the last clear and flags
// the cycle whose closing edge is the TIMEOUT_CYC-th edge after that clear.
module byte_timeout
    import uart_frame_pkg::*;
#(
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam logic [TIMER_W-1:0] LAST_COUNT = TIMER_W'(TIMEOUT_CYC - 1);

    logic [TIMER_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != LAST_COUNT)) begin
            count <= count + TIMER_W'(1);
        end
    end

    assign expired = enable && (count == LAST_COUNT);

endmodule

// File: rtl/uart_frame_ctrl.sv
// Frame controller: hunts for HEADER, collects 5 payload bytes plus checksum and validates them.
// Define UART_FRAME_ACK_EN to answer every checked frame with ACK_BYTE/NAK_BYTE on the shared transmitter.
module uart_frame_ctrl
    import uart_frame_pkg::*;
#(
    parameter logic [7:0] HEADER      = DEFAULT_HEADER,
    parameter int         TIMEOUT_CYC = 50000,
    parameter logic [7:0] ACK_BYTE    = DEFAULT_ACK_BYTE,
    parameter logic [7:0] NAK_BYTE    = DEFAULT_NAK_BYTE
) (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic        RX_Done_Sig,
    input  logic [7:0]  RX_Data,
    input  logic        TX_Done_Sig,
    output logic        TX_En_Sig,
    output logic [7:0]  TX_Data,
    output logic [39:0] Data,
    output logic        Frame_Valid,
    output logic [7:0]  Err_Cnt,
    output logic        Busy
);
    localparam logic [2:0] LAST_IDX = 3'(FRAME_LEN - 1);

    frame_state_t state, state_next;
    logic [2:0]   byte_idx;
    logic [7:0]   sum;
    logic [39:0]  payload;
    logic         start_frame, accept_byte, drop_frame, check_now, frame_good;
    logic         timer_clear, timer_enable, timer_expired;

    assign timer_enable = (state == ST_RECV);
    assign timer_clear  = !timer_enable || RX_Done_Sig;

    byte_timeout #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_byte_timeout (
        .clk    (CLK),
        .rst_n  (RSTn),
        .clear  (timer_clear),
        .enable (timer_enable),
        .expired(timer_expired)
    );

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A byte landing on the expiry edge takes priority over the timeout.
    always_comb begin
        state_next  = state;
        start_frame = 1'b0;
        accept_byte = 1'b0;
        drop_frame  = 1'b0;
        check_now   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (RX_Done_Sig && (RX_Data == HEADER)) begin
                    start_frame = 1'b1;
                    state_next  = ST_RECV;
                end
            end
            ST_RECV: begin
                if (RX_Done_Sig) begin
                    accept_byte = 1'b1;
                    if (byte_idx == LAST_IDX) begin
                        state_next = ST_CHECK;
                    end
                end else if (timer_expired) begin
                    drop_frame = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            ST_CHECK: begin
                check_now = 1'b1;
`ifdef UART_FRAME_ACK_EN
                state_next = ST_TX_REQ;
`else
                state_next = ST_IDLE;
`endif
            end
            ST_TX_REQ: begin
`ifdef UART_FRAME_ACK_EN
                if (TX_Done_Sig) begin
                    state_next = ST_IDLE;
                end
`else
                state_next = ST_IDLE;
`endif
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // The running sum includes the checksum byte, so a good frame ends at zero.
    assign frame_good = (sum == 8'd0);

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            byte_idx    <= '0;
            sum         <= '0;
            payload     <= '0;
            Data        <= '0;
            Frame_Valid <= 1'b0;
            Err_Cnt     <= '0;
        end else begin
            Frame_Valid <= 1'b0;
            if (start_frame) begin
                byte_idx <= '0;
                sum      <= '0;
            end
            if (accept_byte) begin
                byte_idx <= byte_idx + 3'd1;
                sum      <= sum + RX_Data;
                if (byte_idx < LAST_IDX) begin
                    payload <= {payload[31:0], RX_Data};
                end
            end
            if (check_now) begin
                if (frame_good) begin
                    Data        <= payload;
                    Frame_Valid <= 1'b1;
                end else begin
                    Err_Cnt <= sat_inc8(Err_Cnt);
                end
            end
            if (drop_frame) begin
                Err_Cnt <= sat_inc8(Err_Cnt);
            end
        end
    end

    assign Busy = (state != ST_IDLE);

`ifdef UART_FRAME_ACK_EN
    logic [7:0] reply_byte;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            reply_byte <= '0;
        end else if (check_now) begin
            reply_byte <= frame_good ? ACK_BYTE : NAK_BYTE;
        end
    end

    assign TX_En_Sig = (state == ST_TX_REQ);
    assign TX_Data   = reply_byte;
`else
    logic [16:0] unused_tx_cfg;

    assign unused_tx_cfg = {TX_Done_Sig, ACK_BYTE, NAK_BYTE};
    assign TX_En_Sig     = 1'b0;
    assign TX_Data       = 8'h00;
`endif

endmodule

// File: tb/tb_uart_frame_ctrl.sv
// Self-checking bench for uart_frame_ctrl: directed frames, a frame-level reference model
// compared every cycle, and hand-computed literal expectations. Honours UART_FRAME_ACK_EN.
module tb_uart_frame_ctrl;

    localparam int TMO = 100;

`ifdef UART_FRAME_ACK_EN
    localparam logic EXP_TX_EN = 1'b1;
`else
    localparam logic EXP_TX_EN = 1'b0;
`endif

    logic        CLK         = 1'b0;
    logic        RSTn        = 1'b1;
    logic        RX_Done_Sig = 1'b0;
    logic [7:0]  RX_Data     = 8'h00;
    logic        TX_Done_Sig = 1'b0;
    logic        TX_En_Sig;
    logic [7:0]  TX_Data;
    logic [39:0] Data;
    logic        Frame_Valid;
    logic [7:0]  Err_Cnt;
    logic        Busy;

    int n_checks = 0;
    int n_fail   = 0;
    bit checking_on = 1'b0;

    // Reference model state
    logic [7:0]  q[$];
    bit          in_frame = 1'b0;
    bit          judging  = 1'b0;
    bit          replying = 1'b0;
    int          quiet    = 0;
    logic [39:0] m_data   = '0;
    logic        m_fv     = 1'b0;
    int          m_err    = 0;
`ifdef UART_FRAME_ACK_EN
    logic [7:0]  m_tx_data = '0;
`endif

    logic [7:0]  tx_log[$];
    int          fv_pulses    = 0;
    int          tx_en_cycles = 0;

    uart_frame_ctrl #(
        .TIMEOUT_CYC(TMO)
    ) dut (
        .CLK        (CLK),
        .RSTn       (RSTn),
        .RX_Done_Sig(RX_Done_Sig),
        .RX_Data    (RX_Data),
        .TX_Done_Sig(TX_Done_Sig),
        .TX_En_Sig  (TX_En_Sig),
        .TX_Data    (TX_Data),
        .Data       (Data),
        .Frame_Valid(Frame_Valid),
        .Err_Cnt    (Err_Cnt),
        .Busy       (Busy)
    );

    always #5 CLK = ~CLK;

    task automatic checkOutput(input string name, input logic [39:0] actual, input logic [39:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        @(posedge CLK); #1;
        RX_Done_Sig = 1'b1;
        RX_Data     = b;
        @(posedge CLK); #1;
        RX_Done_Sig = 1'b0;
        RX_Data     = 8'h00;
    endtask

    task automatic sendFrame(input logic [55:0] f);
        for (int i = 6; i >= 0; i--) applyStimulus(f[i*8 +: 8]);
    endtask

    task automatic waitIdle(input string tag);
        int k;
        k = 0;
        while (Busy && (k < 100)) begin
            @(posedge CLK); #1;
            k++;
        end
        checkOutput({tag, " returns idle"}, 40'(Busy), 40'd0);
    endtask

    // Frame-level model: bytes are queued, the checksum is judged over the whole queue.
    initial begin
        forever begin
            @(posedge CLK or negedge RSTn);
            if (!RSTn) begin
                q.delete();
                in_frame = 1'b0;
                judging  = 1'b0;
                replying = 1'b0;
                quiet    = 0;
                m_data   = '0;
                m_fv     = 1'b0;
                m_err    = 0;
`ifdef UART_FRAME_ACK_EN
                m_tx_data = '0;
`endif
            end else begin
                m_fv = 1'b0;
                if (judging) begin
                    int s;
                    s = 0;
                    foreach (q[i]) s += int'(q[i]);
                    judging = 1'b0;
                    if ((s % 256) == 0) begin
                        m_data = {q[0], q[1], q[2], q[3], q[4]};
                        m_fv   = 1'b1;
`ifdef UART_FRAME_ACK_EN
                        m_tx_data = 8'h06;
`endif
                    end else begin
                        m_err = (m_err < 255) ? m_err + 1 : 255;
`ifdef UART_FRAME_ACK_EN
                        m_tx_data = 8'h15;
`endif
                    end
                    q.delete();
`ifdef UART_FRAME_ACK_EN
                    replying = 1'b1;
`endif
                end else if (replying) begin
                    if (TX_Done_Sig) replying = 1'b0;
                end else if (in_frame) begin
                    if (RX_Done_Sig) begin
                        q.push_back(RX_Data);
                        quiet = 0;
                        if (q.size() == 6) begin
                            in_frame = 1'b0;
                            judging  = 1'b1;
                        end
                    end else begin
                        quiet++;
                        if (quiet == TMO) begin
                            in_frame = 1'b0;
                            q.delete();
                            m_err = (m_err < 255) ? m_err + 1 : 255;
                        end
                    end
                end else if (RX_Done_Sig && (RX_Data == 8'hAA)) begin
                    in_frame = 1'b1;
                    quiet    = 0;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge CLK);
            if (checking_on) begin
                checkOutput("model Data", Data, m_data);
                checkOutput("model Frame_Valid", 40'(Frame_Valid), 40'(m_fv));
                checkOutput("model Err_Cnt", 40'(Err_Cnt), 40'(m_err));
                checkOutput("model Busy", 40'(Busy), 40'(in_frame || judging || replying));
                checkOutput("model TX_En_Sig", 40'(TX_En_Sig), 40'(replying));
`ifdef UART_FRAME_ACK_EN
                if (replying) checkOutput("model TX_Data", 40'(TX_Data), 40'(m_tx_data));
`else
                checkOutput("model TX_Data", 40'(TX_Data), 40'd0);
`endif
                if (Frame_Valid) fv_pulses++;
                if (TX_En_Sig) tx_en_cycles++;
            end
        end
    end

    // Transmitter stand-in: completes each request after three cycles of TX_En_Sig.
    initial begin
        int hold;
        hold = 0;
        forever begin
            @(posedge CLK); #1;
            TX_Done_Sig = 1'b0;
            if (TX_En_Sig) begin
                hold++;
                if (hold == 3) begin
                    TX_Done_Sig = 1'b1;
                    tx_log.push_back(TX_Data);
                    hold = 0;
                end
            end else begin
                hold = 0;
            end
        end
    end

    initial begin
        #600000;
        $display("[TB] FAIL watchdog: time limit reached, got t=%0t, expected completion earlier", $time);
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int k;
        #2 RSTn = 1'b0;
        checking_on = 1'b1;
        repeat (2) @(negedge CLK);
        #1;
        checkOutput("reset Data", Data, 40'd0);
        checkOutput("reset Frame_Valid", 40'(Frame_Valid), 40'd0);
        checkOutput("reset Err_Cnt", 40'(Err_Cnt), 40'd0);
        checkOutput("reset TX_En_Sig", 40'(TX_En_Sig), 40'd0);
        checkOutput("reset TX_Data", 40'(TX_Data), 40'd0);
        checkOutput("reset Busy", 40'(Busy), 40'd0);
        @(negedge CLK);
        RSTn = 1'b1;

        $display("[TB] good frame");
        sendFrame(56'hAA_11_22_33_44_55_01);
        @(negedge CLK);
        checkOutput("good FV low during CHECK", 40'(Frame_Valid), 40'd0);
        checkOutput("good Busy during CHECK", 40'(Busy), 40'd1);
        @(negedge CLK);
        checkOutput("good FV pulse", 40'(Frame_Valid), 40'd1);
        checkOutput("good Data", Data, 40'h1122334455);
        checkOutput("good TX_En rise", 40'(TX_En_Sig), 40'(EXP_TX_EN));
        @(negedge CLK);
        checkOutput("good FV single cycle", 40'(Frame_Valid), 40'd0);
        waitIdle("good");
        checkOutput("good Err_Cnt", 40'(Err_Cnt), 40'd0);
`ifdef UART_FRAME_ACK_EN
        checkOutput("good ACK sent", 40'(tx_log.size() > 0 ? tx_log[tx_log.size()-1] : 8'h00), 40'h06);
`endif

        $display("[TB] bad checksum");
        sendFrame(56'hAA_11_22_33_44_55_02);
        waitIdle("bad");
        checkOutput("bad Err_Cnt", 40'(Err_Cnt), 40'd1);
        checkOutput("bad Data kept", Data, 40'h1122334455);
        checkOutput("bad no FV", 40'(fv_pulses), 40'd1);
`ifdef UART_FRAME_ACK_EN
        checkOutput("bad NAK sent", 40'(tx_log[tx_log.size()-1]), 40'h15);
`endif

        $display("[TB] noise before header");
        applyStimulus(8'h00);
        applyStimulus(8'hFF);
        sendFrame(56'hAA_01_02_03_04_05_F1);
        waitIdle("noise");
        checkOutput("noise Data", Data, 40'h0102030405);
        sendFrame(56'hAA_01_AA_03_04_05_49);
        waitIdle("inner header");
        checkOutput("inner header Data", Data, 40'h01AA030405);
        checkOutput("inner header Err_Cnt", 40'(Err_Cnt), 40'd1);

        $display("[TB] timeout");
        applyStimulus(8'hAA);
        applyStimulus(8'h01);
        applyStimulus(8'h02);
        repeat (TMO - 1) @(posedge CLK);
        #1;
        checkOutput("timeout still busy one edge early", 40'(Busy), 40'd1);
        checkOutput("timeout Err_Cnt before expiry", 40'(Err_Cnt), 40'd1);
        @(posedge CLK); #1;
        checkOutput("timeout dropped to idle", 40'(Busy), 40'd0);
        checkOutput("timeout Err_Cnt", 40'(Err_Cnt), 40'd2);
        checkOutput("timeout no TX", 40'(TX_En_Sig), 40'd0);
        sendFrame(56'hAA_10_20_30_40_50_10);
        waitIdle("after timeout");
        checkOutput("after timeout Data", Data, 40'h1020304050);

        $display("[TB] byte on the expiry edge");
        applyStimulus(8'hAA);
        applyStimulus(8'h05);
        repeat (TMO - 2) @(posedge CLK);
        applyStimulus(8'h04);
        applyStimulus(8'h03);
        applyStimulus(8'h02);
        applyStimulus(8'h01);
        applyStimulus(8'hF1);
        waitIdle("late byte");
        checkOutput("late byte Data", Data, 40'h0504030201);
        checkOutput("late byte Err_Cnt", 40'(Err_Cnt), 40'd2);

        $display("[TB] reset mid-activity");
`ifdef UART_FRAME_ACK_EN
        sendFrame(56'hAA_11_22_33_44_55_01);
        k = 0;
        while (!TX_En_Sig && (k < 20)) begin
            @(posedge CLK); #1;
            k++;
        end
        checkOutput("reset TX_En reached", 40'(TX_En_Sig), 40'd1);
`else
        applyStimulus(8'hAA);
        applyStimulus(8'h01);
        applyStimulus(8'h02);
        checkOutput("reset frame in progress", 40'(Busy), 40'd1);
`endif
        RSTn = 1'b0;
        #1;
        checkOutput("mid reset Data", Data, 40'd0);
        checkOutput("mid reset Err_Cnt", 40'(Err_Cnt), 40'd0);
        checkOutput("mid reset TX_En_Sig", 40'(TX_En_Sig), 40'd0);
        checkOutput("mid reset TX_Data", 40'(TX_Data), 40'd0);
        checkOutput("mid reset Busy", 40'(Busy), 40'd0);
        checkOutput("mid reset Frame_Valid", 40'(Frame_Valid), 40'd0);
        repeat (2) @(negedge CLK);
        RSTn = 1'b1;
        sendFrame(56'hAA_11_22_33_44_55_01);
        waitIdle("after reset");
        checkOutput("after reset Data", Data, 40'h1122334455);
        checkOutput("after reset Err_Cnt", 40'(Err_Cnt), 40'd0);

        $display("[TB] error counter saturation");
        for (int n = 0; n < 260; n++) begin
            sendFrame(56'hAA_00_00_00_00_00_01);
            waitIdle("saturation");
        end
        checkOutput("saturation Err_Cnt", 40'(Err_Cnt), 40'd255);
        checkOutput("saturation Data kept", Data, 40'h1122334455);

`ifdef UART_FRAME_ACK_EN
        checkOutput("total replies sent", 40'(tx_log.size()), 40'd267);
`else
        checkOutput("TX_En never raised", 40'(tx_en_cycles), 40'd0);
        checkOutput("no replies sent", 40'(tx_log.size()), 40'd0);
`endif

        repeat (2) @(negedge CLK);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_frame_ctrl.md
# uart_frame_ctrl

Receive-side frame controller that sits between the UART receiver and the application logic. It sequences the raw RX byte stream into checksummed 5-byte command frames. It hunts for a header byte, enforces an inter-byte timeout, and validates the 8-bit checksum. It publishes good payloads with a one-cycle strobe and, when enabled, schedules an ACK/NAK byte on the shared UART transmitter.

## Interface
- `HEADER`, 8'hAA: frame start byte; it is not included in the checksum.
- `TIMEOUT_CYC`, 50000: maximum number of CLK cycles allowed between consecutive frame bytes.
- `ACK_BYTE`, 8'h06: byte sent after a good frame.
- `NAK_BYTE`, 8'h15: byte sent after a bad checksum.
- `CLK` in 1: system clock. One clock domain; all logic is rising-edge.
- `RSTn` in 1: asynchronous, active-low reset.
- `RX_Done_Sig` in 1: one-cycle pulse; `RX_Data` is valid in that cycle.
- `RX_Data` in 8: received byte.
- `TX_Done_Sig` in 1: one-cycle pulse from the UART transmitter when the byte has been sent.
- `TX_En_Sig` out 1: transmit request. Held high until `TX_Done_Sig`.
- `TX_Data` out 8: byte to transmit. Stable while `TX_En_Sig` is high.
- `Data` out 40: last good payload, {B1,B2,B3,B4,B5}, with B1 in bits [39:32].
- `Frame_Valid` out 1: one-cycle strobe; `Data` has just been updated.
- `Err_Cnt` out 8: count of bad-checksum and timed-out frames. Saturates at 255.
- `Busy` out 1: high in every state except IDLE.

## Operation
- Reset values: `Data`=0, `Frame_Valid`=0, `Err_Cnt`=0, `TX_En_Sig`=0, `TX_Data`=0, `Busy`=0, state=IDLE.
- **IDLE:** on `RX_Done_Sig` with `RX_Data`==`HEADER`:
  - go to RECV, clear the byte index and the running sum.
  - Any other byte is discarded.
- **RECV:** each `RX_Data` byte is stored at index 0..5 and added to the running sum (8-bit, wrapping).
  - Indices 0..4 are payload; index 5 is the checksum byte.
  - A `HEADER` value inside RECV is treated as data; there is no resync.
  - After index 5 is stored, go to CHECK.
- **CHECK** (one cycle): the frame is good when sum(B1..B5, CK) mod 256 == 0.
  - Good frame: latch `Data`, pulse `Frame_Valid`, select `ACK_BYTE`.
  - Bad frame: `Data` is unchanged, `Err_Cnt`+1 (saturating), select `NAK_BYTE`.
  - Then go to TX_REQ.
- **TX_REQ:** assert `TX_En_Sig` with `TX_Data` set to the selected byte. On `TX_Done_Sig`, deassert and go to IDLE.
- **Timeout:**
  - In RECV the idle counter resets on every `RX_Done_Sig`.
  - When it reaches `TIMEOUT_CYC`: drop the frame, `Err_Cnt`+1, go to IDLE. No ACK/NAK is sent.
- RX bytes arriving in CHECK or TX_REQ are ignored.
- Reset asserted mid-frame or mid-transmit returns all state and outputs to reset values immediately.

## Timing
- Checksum byte accepted at edge T:
  - CHECK occupies cycle T+1.
  - `Data` is updated and `Frame_Valid` is high during cycle T+2 only.
  - `TX_En_Sig` rises at T+2.
- `TX_Done_Sig` at edge U: `TX_En_Sig` is low and the state is IDLE from U+1. A header arriving at U+1 is accepted.
- Timeout: when the last byte arrives at edge T, the frame is dropped at edge T+`TIMEOUT_CYC`. A byte arriving exactly at that edge wins: it resets the counter and is accepted.
- `Err_Cnt` updates at the same edge as the `Frame_Valid` slot (bad frame) or at the timeout edge.

## Configuration
- `UART_FRAME_ACK_EN` defined:
  - TX_REQ is compiled in; the ACK/NAK behaviour is as described above.
- `UART_FRAME_ACK_EN` not defined:
  - TX_REQ is removed and CHECK returns directly to IDLE at T+2.
  - `TX_En_Sig` and `TX_Data` are tied to 0. `TX_Done_Sig` is ignored.
  - All other timing is unchanged.

## Structure
- Package `uart_frame_pkg` holds:
  - state encodings (IDLE, RECV, CHECK, TX_REQ);
  - default `HEADER`, `ACK_BYTE`, `NAK_BYTE`;
  - the frame length constant (6).
- Sub-module `byte_timeout`:
  - clear/enable inputs;
  - 16-bit cycle counter;
  - `expired` output. Parameterised by `TIMEOUT_CYC`.

## Test plan
- **Good frame:** AA 11 22 33 44 55 01 (sum 0x100 → 0). `Data`=40'h1122334455 and one `Frame_Valid` pulse at T+2. `TX_Data`=06 is sent. `Err_Cnt`=0.
- **Bad checksum:** AA 11 22 33 44 55 02. `Data` is unchanged, no `Frame_Valid`, `Err_Cnt`=1, `TX_Data`=15 is sent.
- **Noise before the header:** 00 FF AA 01 02 03 04 05 F1. Leading bytes are ignored; `Data`=40'h0102030405. Include an AA inside the payload, which must be accepted as data.
- **Timeout:** with `TIMEOUT_CYC`=100, send AA 01 02 and then stop. IDLE is reached 100 cycles after the byte 02, `Err_Cnt`=1, no TX. The next full good frame is accepted.
- **Saturation:** 260 bad frames leave `Err_Cnt`=255.
- **Reset mid-TX:** pulse `RSTn` low while `TX_En_Sig`=1. All outputs read 0 at once; a following good frame completes normally. Repeat the good-frame case with `UART_FRAME_ACK_EN` undefined: `TX_En_Sig` stays 0 throughout.
